frame_builder: RTL and testbench

FRAME_BUILDER -- requirements
Module: frame_builder

---
 rtl/frame_builder.sv | 185 ++++++++++++++++++
 tb/tb_frame_builder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_builder.sv
// Frame builder: emits a pi/2-BPSK start-of-frame preamble and then the payload samples,
// with optional pilot blocks inserted between them, through a registered valid/ready output.
module frame_builder #(
  parameter int unsigned W            = 12,
  parameter int unsigned SOF_LEN      = 26,
  parameter logic [63:0] SOF_PATTERN  = 64'h18D2E82,
  parameter int unsigned PAYLOAD_LEN  = 63,
  parameter int unsigned AMP          = 1447,
  parameter int unsigned PILOT_PERIOD = 0,
  parameter int unsigned PILOT_LEN    = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_i,
  input  logic [W-1:0] in_q,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_q,
  input  logic         out_ready,
  output logic         out_sof,
  output logic         out_pilot,
  output logic         out_last,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [1:0] {StIdle, StSof, StPayload, StPilot} state_e;

  localparam logic [W-1:0] AmpPos  = AMP[W-1:0];
  localparam logic [W-1:0] AmpNeg  = ~AmpPos + 1'b1;
  localparam bit           PilotEn = (PILOT_PERIOD > 0);

  state_e        state_q, state_d;
  logic [7:0]    sym_q, sym_d;
  logic [15:0]   pay_q, pay_d;
  logic [15:0]   pil_q, pil_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  // Set for the one cycle after a frame end; a low in_valid then drops back to idle.
  logic          chk_q, chk_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_pilot_q, out_pilot_d;
  logic          out_last_q, out_last_d;
  logic [W-1:0]  out_i_q, out_i_d;
  logic [W-1:0]  out_q_q, out_q_d;

  logic          slot;
  logic          accept;
  logic          pay_last;
  logic          pil_hit;
  logic [5:0]    sof_idx;
  logic          sof_bit;

  assign slot     = out_ready || !out_valid_q;
  assign in_ready = (state_q == StPayload) && slot;
  assign accept   = in_valid && in_ready;
  assign pay_last = (pay_q == 16'(PAYLOAD_LEN - 1));
  assign pil_hit  = PilotEn && (pil_q == 16'(PILOT_PERIOD - 1));
  assign sof_idx  = 6'(SOF_LEN - 1) - sym_q[5:0];
  assign sof_bit  = SOF_PATTERN[sof_idx];

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    pay_d       = pay_q;
    pil_d       = pil_q;
    frame_cnt_d = frame_cnt_q;
    chk_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_pilot_d = out_pilot_q;
    out_last_d  = out_last_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;

    // A slot with nothing to emit empties the output register.
    if (slot) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_pilot_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StSof;
      end
      StSof: begin
        if (chk_q && !in_valid) begin
          state_d = StIdle;
        end else if (slot) begin
          out_valid_d = 1'b1;
          out_sof_d   = (sym_q == 8'd0);
          out_q_d     = sof_bit ? AmpNeg : AmpPos;
          // Odd symbols rotate by pi/2, which flips the sign of I only.
          out_i_d     = (sof_bit ^ sym_q[0]) ? AmpNeg : AmpPos;
          if (sym_q == 8'(SOF_LEN - 1)) begin
            sym_d   = 8'd0;
            state_d = StPayload;
          end else begin
            sym_d = sym_q + 8'd1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_i_d     = in_i;
          out_q_d     = in_q;
          out_last_d  = pay_last;
          if (pay_last) begin
            pay_d       = 16'd0;
            pil_d       = 16'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            chk_d       = 1'b1;
            state_d     = StSof;
          end else begin
            pay_d = pay_q + 16'd1;
            if (pil_hit) begin
              pil_d   = 16'd0;
              state_d = StPilot;
            end else begin
              pil_d = pil_q + 16'd1;
            end
          end
        end
      end
      StPilot: begin
        if (slot) begin
          out_valid_d = 1'b1;
          out_pilot_d = 1'b1;
          out_i_d     = AmpPos;
          out_q_d     = AmpPos;
          if (sym_q == 8'(PILOT_LEN - 1)) begin
            sym_d   = 8'd0;
            state_d = StPayload;
          end else begin
            sym_d = sym_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sym_q       <= '0;
      pay_q       <= '0;
      pil_q       <= '0;
      frame_cnt_q <= '0;
      chk_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_pilot_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      pay_q       <= pay_d;
      pil_q       <= pil_d;
      frame_cnt_q <= frame_cnt_d;
      chk_q       <= chk_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_pilot_q <= out_pilot_d;
      out_last_q  <= out_last_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_pilot = out_pilot_q;
  assign out_last  = out_last_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder: a default instance (index 0) and a pilot-enabled
// instance (index 1, PILOT_PERIOD=16, PILOT_LEN=4, PAYLOAD_LEN=32).
module tb_frame_builder;

  localparam logic [25:0] SOF_PAT = 26'h18D2E82;
  localparam logic [11:0] AP      = 12'd1447;
  localparam logic [11:0] AN      = 12'hA59;

  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
    logic        sof;
    logic        pilot;
    logic        last;
  } sym_t;

  typedef struct {
    int   g;
    int   idx;
    sym_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [11:0] in_i      [2];
  logic [11:0] in_q      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [11:0] out_i     [2];
  logic [11:0] out_q     [2];
  logic        out_sof   [2];
  logic        out_pilot [2];
  logic        out_last  [2];
  logic [15:0] frame_cnt [2];

  int   n_smp   [2];
  bit   tog     [2];
  sym_t cap     [2][0:511];
  int   cap_cyc [2][0:511];
  int   ncap    [2];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  frame_builder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_i(in_i[0]), .in_q(in_q[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_i(out_i[0]), .out_q(out_q[0]),
    .out_ready(out_ready[0]), .out_sof(out_sof[0]), .out_pilot(out_pilot[0]),
    .out_last(out_last[0]), .frame_cnt(frame_cnt[0])
  );

  frame_builder #(.PILOT_PERIOD(16), .PILOT_LEN(4), .PAYLOAD_LEN(32)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_i(in_i[1]), .in_q(in_q[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_i(out_i[1]), .out_q(out_q[1]),
    .out_ready(out_ready[1]), .out_sof(out_sof[1]), .out_pilot(out_pilot[1]),
    .out_last(out_last[1]), .frame_cnt(frame_cnt[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected symbol at position idx since the last reset; payload sample n carries (n+1, -(n+1)).
  function automatic sym_t model(input int idx, input int pl, input int pper, input int plen);
    int flen, f, p, seg, off, j, n;
    logic b;
    sym_t s;
    flen = 26 + pl + ((pper > 0) ? plen * ((pl - 1) / pper) : 0);
    f = idx / flen;
    p = idx % flen;
    s = '0;
    if (p < 26) begin
      b     = SOF_PAT[25 - p];
      s.q   = b ? AN : AP;
      s.i   = (p % 2 == 0) ? (b ? AN : AP) : (b ? AP : AN);
      s.sof = (p == 0);
    end else begin
      p -= 26;
      if (pper > 0) begin
        seg = p / (pper + plen);
        off = p % (pper + plen);
      end else begin
        seg = 0;
        off = p;
      end
      if (pper > 0 && off >= pper) begin
        s.i = AP;
        s.q = AP;
        s.pilot = 1'b1;
      end else begin
        j = seg * pper + off;
        n = f * pl + j + 1;
        s.i = 12'(n);
        s.q = 12'(-n);
        s.last = (j == pl - 1);
      end
    end
    return s;
  endfunction

  task automatic compare_run(input int g, input int cnt, input int pl, input int pper,
                             input int plen, input string name, input bit contiguous);
    for (int k = 0; k < cnt; k++) begin
      check(name, cap[g][k], model(k, pl, pper, plen));
      if (contiguous && k > 0 && cap[g][k-1].last)
        check({name, "_b2b_gap"}, cap_cyc[g][k] - cap_cyc[g][k-1], 1);
    end
    if (contiguous) check({name, "_span"}, cap_cyc[g][cnt-1] - cap_cyc[g][0], cnt - 1);
  endtask

  task automatic wait_caps(input int g, input int cnt, input int budget);
    int t = 0;
    while (ncap[g] < cnt && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("wait_caps", ncap[g] >= cnt, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      n_smp[g] = 0;
      ncap[g]  = 0;
      tog[g]   = 1'b0;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    assign in_i[g] = 12'(n_smp[g] + 1);
    assign in_q[g] = 12'(-(n_smp[g] + 1));

    initial begin : src
      bit acc;
      forever begin
        @(negedge clk);
        acc = in_valid[g] && in_ready[g];
        @(posedge clk);
        #1;
        if (acc) n_smp[g]++;
        out_ready[g] = tog[g] ? !out_ready[g] : 1'b1;
      end
    end

    initial begin : mon
      sym_t cur, hold;
      bit   hold_v;
      hold_v = 1'b0;
      forever begin
        @(negedge clk);
        cur = '{i: out_i[g], q: out_q[g], sof: out_sof[g], pilot: out_pilot[g],
                last: out_last[g]};
        if (hold_v) check("stall_hold", {out_valid[g], cur}, {1'b1, hold});
        hold   = cur;
        hold_v = out_valid[g] && !out_ready[g] && !rst;
        if (out_valid[g] && out_ready[g] && ncap[g] < 512) begin
          cap[g][ncap[g]]     = cur;
          cap_cyc[g][ncap[g]] = cyc;
          ncap[g]++;
        end
      end
    end
  end

  initial begin
    vec_t vecs[14];
    int   t;

    vecs[0]  = '{0, 0,   '{AP, AP, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{0, 1,   '{AP, AN, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{0, 2,   '{AN, AN, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{0, 3,   '{AN, AP, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{0, 26,  '{12'd1, 12'hFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{0, 88,  '{12'd63, 12'hFC1, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{0, 89,  '{AP, AP, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{0, 177, '{12'd126, 12'hF82, 1'b0, 1'b0, 1'b1}};
    vecs[8]  = '{1, 41,  '{12'd16, 12'hFF0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{1, 42,  '{AP, AP, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{1, 45,  '{AP, AP, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{1, 46,  '{12'd17, 12'hFEF, 1'b0, 1'b0, 1'b0}};
    vecs[12] = '{1, 61,  '{12'd32, 12'hFE0, 1'b0, 1'b0, 1'b1}};
    vecs[13] = '{1, 62,  '{AP, AP, 1'b1, 1'b0, 1'b0}};

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      tog[g]       = 1'b0;
      n_smp[g]     = 0;
      ncap[g]      = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", out_valid[0], 1'b0);
    check("rst_data", {out_i[0], out_q[0]}, 24'd0);
    check("rst_flags", {out_sof[0], out_pilot[0], out_last[0]}, 3'b000);
    check("rst_frame_cnt", frame_cnt[0], 16'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("idle_valid", out_valid[0], 1'b0);
    check("idle_ready", in_ready[0], 1'b0);

    // Back-to-back frames on both instances.
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    wait_caps(0, 267, 2000);
    check("frame_cnt_3", frame_cnt[0], 16'd3);
    wait_caps(1, 63, 500);
    compare_run(0, 267, 63, 0, 36, "dflt_seq", 1'b1);
    compare_run(1, 63, 32, 16, 4, "pilot_seq", 1'b1);
    for (int v = 0; v < 14; v++)
      check($sformatf("vec%0d", v), cap[vecs[v].g][vecs[v].idx], vecs[v].exp);

    // Reset in the middle of the fourth frame's payload.
    t = 0;
    while (n_smp[0] < 200 && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("reach_mid_payload", n_smp[0] >= 200, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid[0], 1'b0);
    check("midrst_frame_cnt", frame_cnt[0], 16'd0);
    for (int g = 0; g < 2; g++) begin
      n_smp[g] = 0;
      ncap[g]  = 0;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_caps(0, 1, 100);
    check("post_rst_first", cap[0][0], {AP, AP, 1'b1, 1'b0, 1'b0});

    // Upstream gap of 5 cycles after payload sample 10.
    t = 0;
    while (n_smp[0] < 11 && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("reach_sample_10", n_smp[0], 11);
    in_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("gap_valid", out_valid[0], 1'b0);
        check("gap_still_payload", in_ready[0], 1'b1);
      end
    end
    @(posedge clk);
    #2;
    in_valid[0] = 1'b1;
    wait_caps(0, 90, 500);
    compare_run(0, 90, 63, 0, 36, "gap_seq", 1'b0);
    check("gap_frame_cnt", frame_cnt[0], 16'd1);

    // Output stalled every other cycle.
    do_reset();
    tog[0] = 1'b1;
    wait_caps(0, 90, 1000);
    tog[0] = 1'b0;
    compare_run(0, 90, 63, 0, 36, "stall_seq", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
